// File: rtl/life_pkg.sv
// Shared types, constants and small helpers for the Game of Life grid engine.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RAND = 2'd2
  } life_state_t;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  localparam int          NBR_W      = 4;

  // Population count of the eight neighbour bits, 0..8.
  function automatic logic [NBR_W-1:0] count_nbrs(input logic [7:0] nb);
    logic [NBR_W-1:0] n;
    n = {NBR_W{1'b0}};
    for (int i = 0; i < 8; i++) begin
      n = n + {{(NBR_W-1){1'b0}}, nb[i]};
    end
    return n;
  endfunction

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/life_cell.sv
// One Game of Life cell: B3/S23 rule applied to the current state and neighbour count.
module life_cell
  import life_pkg::*;
(
  input  logic             alive,
  input  logic [NBR_W-1:0] nbr_count,
  output logic             next_alive
);

  // Two neighbours keep the current state, three always yield a live cell.
  always_comb begin
    case (nbr_count)
      4'd2:    next_alive = alive;
      4'd3:    next_alive = 1'b1;
      default: next_alive = 1'b0;
    endcase
  end

endmodule

// File: rtl/life_grid_engine.sv
// Conway's Game of Life engine: ROWS x COLS cell array with run/step control,
// direct load and LFSR-based random fill.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int WRAP   = 1,
  parameter int SEED_W = 16,
  parameter int GEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic                 randomize,
  input  logic                 seed_load,
  input  logic [SEED_W-1:0]    seed,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] load_data,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 busy,
  output logic                 stable,
  output logic                 extinct
);

  localparam int N     = ROWS * COLS;
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  if (COLS > SEED_W) begin : g_cols_check
    $error("life_grid_engine: COLS must not exceed SEED_W");
  end

  life_state_t       state_r, state_n_s;
  logic [N-1:0]      grid_r, next_s, rand_grid_s;
  logic [GEN_W-1:0]  gen_r;
  logic [SEED_W-1:0] lfsr_r;
  logic [ROW_W-1:0]  row_r;
  logic              busy_r, stable_r, extinct_r;
  logic              gen_en_s, load_en_s, seed_en_s, row_en_s, rand_start_s, rand_done_s;

  // Neighbour wiring: with WRAP=0 the missing edge neighbours are tied dead.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RU = (r + ROWS - 1) % ROWS;
      localparam int RD = (r + 1) % ROWS;
      localparam int CL = (c + COLS - 1) % COLS;
      localparam int CR = (c + 1) % COLS;
      localparam bit HU = (WRAP != 0) || (r > 0);
      localparam bit HD = (WRAP != 0) || (r < ROWS - 1);
      localparam bit HL = (WRAP != 0) || (c > 0);
      localparam bit HR = (WRAP != 0) || (c < COLS - 1);
      logic [7:0]       nb_s;
      logic [NBR_W-1:0] cnt_s;
      assign nb_s[0] = (HU && HL) ? grid_r[RU*COLS+CL] : 1'b0;
      assign nb_s[1] = HU         ? grid_r[RU*COLS+c]  : 1'b0;
      assign nb_s[2] = (HU && HR) ? grid_r[RU*COLS+CR] : 1'b0;
      assign nb_s[3] = HL         ? grid_r[r*COLS+CL]  : 1'b0;
      assign nb_s[4] = HR         ? grid_r[r*COLS+CR]  : 1'b0;
      assign nb_s[5] = (HD && HL) ? grid_r[RD*COLS+CL] : 1'b0;
      assign nb_s[6] = HD         ? grid_r[RD*COLS+c]  : 1'b0;
      assign nb_s[7] = (HD && HR) ? grid_r[RD*COLS+CR] : 1'b0;
      assign cnt_s   = count_nbrs(nb_s);
      life_cell u_cell (
        .alive      (grid_r[r*COLS+c]),
        .nbr_count  (cnt_s),
        .next_alive (next_s[r*COLS+c])
      );
    end
  end

  // Grid image with the current RAND row replaced by the low LFSR bits.
  always_comb begin
    rand_grid_s = grid_r;
    for (int r = 0; r < ROWS; r++) begin
      if (row_r == ROW_W'(r)) begin
        rand_grid_s[r*COLS +: COLS] = lfsr_r[COLS-1:0];
      end else begin
        rand_grid_s[r*COLS +: COLS] = grid_r[r*COLS +: COLS];
      end
    end
  end

  // Next-state and action decode; priority randomize > load > start > step.
  always_comb begin
    state_n_s    = state_r;
    gen_en_s     = 1'b0;
    load_en_s    = 1'b0;
    seed_en_s    = 1'b0;
    row_en_s     = 1'b0;
    rand_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        seed_en_s = seed_load;
        if (randomize) begin
          state_n_s    = ST_RAND;
          rand_start_s = 1'b1;
        end else if (load) begin
          load_en_s = 1'b1;
        end else if (start) begin
          state_n_s = ST_RUN;
          gen_en_s  = 1'b1;
        end else if (step) begin
          gen_en_s = 1'b1;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (randomize) begin
          state_n_s    = ST_RAND;
          rand_start_s = 1'b1;
        end else if (start) begin
          gen_en_s = 1'b1;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RAND: begin
        row_en_s = 1'b1;
        if (row_r == ROW_LAST) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_RAND;
        end
      end
      default: state_n_s = ST_IDLE;
    endcase
    rand_done_s = row_en_s && (row_r == ROW_LAST);
  end

  // Registered state, grid, counters and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      grid_r    <= {N{1'b0}};
      gen_r     <= {GEN_W{1'b0}};
      lfsr_r    <= LFSR_RESET;
      row_r     <= {ROW_W{1'b0}};
      busy_r    <= 1'b0;
      stable_r  <= 1'b0;
      extinct_r <= 1'b1;
    end else begin
      state_r <= state_n_s;
      busy_r  <= (state_n_s == ST_RAND);

      if (rand_start_s)  row_r <= {ROW_W{1'b0}};
      else if (row_en_s) row_r <= row_r + ROW_W'(1);
      else               row_r <= row_r;

      if (seed_en_s)     lfsr_r <= (seed == {SEED_W{1'b0}}) ? SEED_W'(1) : seed;
      else if (row_en_s) lfsr_r <= lfsr_next(lfsr_r);
      else               lfsr_r <= lfsr_r;

      if (load_en_s) begin
        grid_r    <= load_data;
        extinct_r <= (load_data == {N{1'b0}});
      end else if (gen_en_s) begin
        grid_r    <= next_s;
        extinct_r <= (next_s == {N{1'b0}});
      end else if (row_en_s) begin
        grid_r    <= rand_grid_s;
        extinct_r <= (rand_grid_s == {N{1'b0}});
      end else begin
        grid_r    <= grid_r;
        extinct_r <= extinct_r;
      end

      if (load_en_s || rand_done_s) begin
        gen_r    <= {GEN_W{1'b0}};
        stable_r <= 1'b0;
      end else if (gen_en_s) begin
        gen_r    <= gen_r + GEN_W'(1);
        stable_r <= (next_s == grid_r);
      end else begin
        gen_r    <= gen_r;
        stable_r <= stable_r;
      end
    end
  end

  assign grid      = grid_r;
  assign gen_count = gen_r;
  assign busy      = busy_r;
  assign stable    = stable_r;
  assign extinct   = extinct_r;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: toroidal and dead-border instances share stimulus.
module tb_life_grid_engine;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
  localparam logic [63:0] EDGE    = 64'h0000_0000_0000_0083;
  localparam logic [63:0] EDGE_W  = 64'h0100_0000_0000_0101;
  localparam logic [63:0] RAND_1  = 64'h8040_2010_0804_0201;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, step = 1'b0, randomize = 1'b0, seed_load = 1'b0, load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic [63:0] load_data = 64'h0;
  logic [63:0] grid_w, grid_n;
  logic [15:0] gen_w, gen_n;
  logic        busy_w, busy_n, stable_w, stable_n, extinct_w, extinct_n;
  int          total = 0;
  int          bad = 0;
  int          cyc;

  life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1), .SEED_W(16), .GEN_W(16)) dut_w (
    .clk(clk), .reset(reset), .start(start), .step(step), .randomize(randomize),
    .seed_load(seed_load), .seed(seed), .load(load), .load_data(load_data),
    .grid(grid_w), .gen_count(gen_w), .busy(busy_w), .stable(stable_w), .extinct(extinct_w)
  );

  life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(0), .SEED_W(16), .GEN_W(16)) dut_n (
    .clk(clk), .reset(reset), .start(start), .step(step), .randomize(randomize),
    .seed_load(seed_load), .seed(seed), .load(load), .load_data(load_data),
    .grid(grid_n), .gen_count(gen_n), .busy(busy_n), .stable(stable_n), .extinct(extinct_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #12;
    check("rst_grid", grid_w, 64'h0);
    check("rst_gen", {48'h0, gen_w}, 64'h0);
    check("rst_busy", {63'h0, busy_w}, 64'h0);
    check("rst_stable", {63'h0, stable_w}, 64'h0);
    check("rst_extinct", {63'h0, extinct_w}, 64'h1);
    reset = 1'b1;
    tick();

    // blinker, two single steps
    load = 1'b1; load_data = BLINK_H;
    tick();
    load = 1'b0;
    check("load_grid", grid_w, BLINK_H);
    check("load_extinct", {63'h0, extinct_w}, 64'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("blink1_grid", grid_w, BLINK_V);
    check("blink1_gen", {48'h0, gen_w}, 64'h1);
    check("blink1_stable", {63'h0, stable_w}, 64'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("blink2_grid", grid_w, BLINK_H);
    check("blink2_gen", {48'h0, gen_w}, 64'h2);

    // load beats start; block still life
    load = 1'b1; start = 1'b1; load_data = BLOCK;
    tick();
    load = 1'b0; start = 1'b0;
    check("ldstart_grid", grid_w, BLOCK);
    check("ldstart_gen", {48'h0, gen_w}, 64'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("block_grid", grid_w, BLOCK);
    check("block_stable", {63'h0, stable_w}, 64'h1);
    check("block_gen", {48'h0, gen_w}, 64'h1);

    // edge wrap vs dead border
    load = 1'b1; load_data = EDGE;
    tick();
    load = 1'b0;
    check("edge_load_stable", {63'h0, stable_w}, 64'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("wrap1_grid", grid_w, EDGE_W);
    check("wrap0_grid", grid_n, 64'h0);
    check("wrap0_extinct", {63'h0, extinct_n}, 64'h1);
    check("wrap1_extinct", {63'h0, extinct_w}, 64'h0);

    // seeded randomize
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0;
    randomize = 1'b1;
    tick();
    randomize = 1'b0;
    cyc = busy_w ? 1 : 0;
    for (int i = 0; i < 20 && busy_w; i++) begin
      tick();
      if (busy_w) cyc++;
    end
    check("rand_busy_cycles", 64'(cyc), 64'd8);
    check("rand_row0", {56'h0, grid_w[7:0]}, 64'h01);
    check("rand_row1", {56'h0, grid_w[15:8]}, 64'h02);
    check("rand_grid", grid_w, RAND_1);
    check("rand_gen", {48'h0, gen_w}, 64'h0);
    check("rand_stable", {63'h0, stable_w}, 64'h0);

    // continuous run on the blinker
    load = 1'b1; load_data = BLINK_H;
    tick();
    load = 1'b0;
    start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    check("run_gen", {48'h0, gen_w}, 64'd10);
    check("run_grid", grid_w, BLINK_H);
    tick();
    check("run_stop_gen", {48'h0, gen_w}, 64'd10);

    // reset in the middle of a random fill
    randomize = 1'b1;
    tick();
    randomize = 1'b0;
    tick();
    tick();
    check("midrand_busy", {63'h0, busy_w}, 64'h1);
    reset = 1'b0;
    #1;
    check("midrst_grid", grid_w, 64'h0);
    check("midrst_busy", {63'h0, busy_w}, 64'h0);
    check("midrst_extinct", {63'h0, extinct_w}, 64'h1);
    check("midrst_gen", {48'h0, gen_w}, 64'h0);
    #2;
    reset = 1'b1;
    tick();

    // fill from the reset LFSR value ACE1
    randomize = 1'b1;
    tick();
    randomize = 1'b0;
    for (int i = 0; i < 20 && busy_w; i++) begin
      tick();
    end
    check("rstlfsr_busy", {63'h0, busy_w}, 64'h0);
    check("rstlfsr_rows01", {48'h0, grid_w[15:0]}, 64'hC3E1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/life_grid_engine.md
# life_grid_engine

Parametrised Conway's Game of Life engine and the next generation of the team's fixed 8x8 `main` grid block. It holds a ROWS x COLS cell array and advances it one generation per clock while running, or one generation per single-step request. The array can be filled from an on-chip LFSR or loaded directly, with toroidal or dead-border edges. It feeds the display and scan-out path through a flat `grid` bus.

## Interface
- `ROWS`, 8: grid rows, 3..32.
- `COLS`, 8: grid columns, 3..SEED_W. Elaboration fails if `COLS > SEED_W`.
- `WRAP`, 1: 1 = toroidal edges; 0 = cells outside the array are dead.
- `SEED_W`, 16: LFSR width, fixed at 16 in this revision.
- `GEN_W`, 16: generation counter width.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level-sensitive; run continuously while high.
- `step` in 1: one-cycle pulse; advance exactly one generation.
- `randomize` in 1: pulse; fill the grid from the LFSR.
- `seed_load` in 1: load the LFSR from `seed`.
- `seed` in SEED_W: LFSR seed value.
- `load` in 1: write `load_data` into the grid.
- `load_data` in ROWS*COLS: pattern to load.
- `grid` out ROWS*COLS: cell (r,c) at bit r*COLS+c; row 0 is `grid[COLS-1:0]`.
- `gen_count` out GEN_W: generations since the last load, randomize or reset.
- `busy` out 1: high while in RAND.
- `stable` out 1: last generation produced no change.
- `extinct` out 1: grid is all zero.

## Operation
- FSM states: IDLE, RUN, RAND.
- IDLE:
  - `randomize` → RAND.
  - else `load` → grid := `load_data`, `gen_count` := 0.
  - else `start` → RUN.
  - else `step` → one generation, stay in IDLE.
  - `seed_load` is accepted in IDLE only: lfsr := `seed`, or 16'h0001 if `seed` is zero.
- RUN:
  - Each cycle with `start` high computes one generation.
  - `start` low → IDLE without computing.
  - `randomize` → RAND, and has priority over computing.
  - `load`, `step` and `seed_load` are ignored.
- RAND:
  - Row counter runs 0..ROWS-1, writing row r := lfsr[COLS-1:0], then advancing the LFSR one step.
  - After ROWS cycles: return to IDLE, `gen_count` := 0, `stable` := 0.
  - All other inputs are ignored, including re-asserted `randomize`.
- LFSR: Fibonacci, x^16+x^14+x^13+x^11+1; shift left, feedback bit = b15^b13^b12^b10 into bit 0.
- Rule, per cell: live with 2 or 3 live neighbours survives; dead with exactly 3 is born; all others die.
- Neighbour count:
  - 4 bits, range 0..8.
  - WRAP=1: indices wrap modulo ROWS/COLS.
  - WRAP=0: out-of-range neighbours count as 0.
- Generation update:
  - `grid` := next.
  - `gen_count` += 1, wrapping modulo 2^GEN_W.
  - `stable` := (next == grid).
- `extinct` is registered and equals (grid == 0) after every grid write.

## Timing
- Reset values:
  - `grid` = 0, `gen_count` = 0, `busy` = 0, `stable` = 0, `extinct` = 1.
  - lfsr = 16'hACE1, state = IDLE.
- Generation latency: the next grid is visible one cycle after the sampling edge; in RUN, one generation per clock.
- Load: `grid` updates on the sampling edge; `stable` := 0 and `extinct` is updated on the same edge.
- Randomize:
  - `busy` rises the cycle after the `randomize` sample and stays high for exactly ROWS cycles.
  - Row r is written on the r-th RAND edge; the full grid is valid when `busy` falls.
- Simultaneous events:
  - Priority is `randomize` > `load` > `start` > `step`.
  - `step` together with `start` counts as a single generation.
- Reset asserted mid-RAND or mid-RUN: immediate return to reset values; partial rows are discarded.

## Structure
- Package `life_pkg` holds:
  - the state enum `life_state_t`;
  - `LFSR_TAPS` = 16'hB400 and `LFSR_RESET` = 16'hACE1;
  - the neighbour-count width constant.
- Sub-module `life_cell`: inputs alive (1 bit) and nbr_count (4 bits), output next_alive (1 bit), combinational.
- The top level instantiates ROWS*COLS `life_cell` instances via generate; neighbour wiring depends on WRAP.

## Test plan
- Blinker, 8x8, WRAP=1: load 64'h0000_0000_1C00_0000, pulse `step` → `grid` = 64'h0000_0008_0808_0000, `gen_count` = 1; second `step` restores the original, `gen_count` = 2.
- Block still life: load 64'h0000_0000_0000_0303, pulse `step` → grid unchanged, `stable` = 1, `gen_count` = 1.
- Edge wrap:
  - WRAP=1: load 64'h83, `step` → 64'h0100_0000_0000_0101.
  - WRAP=0: same load and `step` → grid 0, `extinct` = 1.
- Randomize: `seed_load` with `seed` = 16'h0001, then `randomize` → `busy` high for 8 cycles, row 0 = 8'h01, row 1 = 8'h02, `gen_count` = 0 at the end.
- Run plus mid-operation reset: hold `start` high for 10 cycles on the blinker → `gen_count` = 10 and grid equals the initial pattern; then assert `reset` mid-RAND → `grid` = 0, `busy` = 0, `extinct` = 1 immediately.
